// File: rtl/logic_op_pipe.sv
// logic_op_pipe
//   Registered two-operand bitwise logic unit (AND / OR / XOR / NOR) with
//   valid/ready handshakes on both sides. A beat with acc_en=1 and last=0
//   opens a frame: the following beats are folded into one accumulated
//   result, which is emitted when the beat with last=1 arrives.
//
// Parameters
//   WIDTH  operand/result width in bits (>=1)
//   CNT_W  width of the saturating beat counter out_count (>=1)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand beat valid
//   in_ready   out  unit can accept a beat (combinational)
//   a, b       in   operands
//   op         in   00 AND, 01 OR, 10 XOR, 11 NOR
//   acc_en     in   beat belongs to an accumulating frame
//   last       in   final beat of frame (ignored when acc_en=0)
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   out        out  result
//   out_count  out  beats folded into result, saturating

module logic_op_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             acc_en,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC  = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Per-beat combine. NOR combines with OR; the inversion is applied once
  // to the final accumulated value so that a frame yields NOR of all operands.
  function automatic logic [WIDTH-1:0] beat_fn(input logic [1:0] f_op,
                                                input logic [WIDTH-1:0] f_a,
                                                input logic [WIDTH-1:0] f_b);
    logic [WIDTH-1:0] r;
    case (f_op)
      OP_AND:  r = f_a & f_b;
      OP_OR:   r = f_a | f_b;
      OP_XOR:  r = f_a ^ f_b;
      OP_NOR:  r = f_a | f_b;
      default: r = f_a | f_b;
    endcase
    return r;
  endfunction

  // Fold a new beat value into the running accumulator.
  function automatic logic [WIDTH-1:0] fold_fn(input logic [1:0] f_op,
                                                input logic [WIDTH-1:0] f_acc,
                                                input logic [WIDTH-1:0] f_x);
    logic [WIDTH-1:0] r;
    case (f_op)
      OP_AND:  r = f_acc & f_x;
      OP_OR:   r = f_acc | f_x;
      OP_XOR:  r = f_acc ^ f_x;
      OP_NOR:  r = f_acc | f_x;
      default: r = f_acc | f_x;
    endcase
    return r;
  endfunction

  // Turn an accumulator into the visible result.
  function automatic logic [WIDTH-1:0] finish_fn(input logic [1:0] f_op,
                                                  input logic [WIDTH-1:0] f_acc);
    logic [WIDTH-1:0] r;
    if (f_op == OP_NOR) begin
      r = ~f_acc;
    end else begin
      r = f_acc;
    end
    return r;
  endfunction

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] f_cnt);
    logic [CNT_W-1:0] r;
    if (f_cnt == CNT_MAX) begin
      r = f_cnt;
    end else begin
      r = f_cnt + CNT_ONE;
    end
    return r;
  endfunction

  state_t           state_r, state_n;
  logic [WIDTH-1:0] acc_r, acc_n;
  logic [1:0]       op_r, op_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [WIDTH-1:0] out_r, out_n;
  logic [CNT_W-1:0] out_count_r, out_count_n;
  logic             out_valid_r, out_valid_n;

  logic             in_ready_s;
  logic             beat_s;
  logic             take_s;
  logic [WIDTH-1:0] new_beat_s;
  logic [WIDTH-1:0] fold_s;
  logic [CNT_W-1:0] cnt_inc_s;

  assign in_ready_s = !out_valid_r || out_ready;
  assign beat_s     = in_valid && in_ready_s;
  assign take_s     = out_valid_r && out_ready;

  // Datapath helpers: fresh beat uses the live op, frame beats use the latched op.
  always_comb begin
    new_beat_s = beat_fn(op, a, b);
    fold_s     = fold_fn(op_r, acc_r, beat_fn(op_r, a, b));
    cnt_inc_s  = sat_inc(cnt_r);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state_r;
    acc_n       = acc_r;
    op_n        = op_r;
    cnt_n       = cnt_r;
    out_n       = out_r;
    out_count_n = out_count_r;
    out_valid_n = out_valid_r;
    case (state_r)
      ST_IDLE, ST_HOLD: begin
        // In HOLD a beat is only accepted when the pending result is taken
        // in the same cycle, so replacing it here loses nothing.
        if (beat_s) begin
          if (!acc_en || last) begin
            acc_n       = new_beat_s;
            cnt_n       = CNT_ONE;
            out_n       = finish_fn(op, new_beat_s);
            out_count_n = CNT_ONE;
            out_valid_n = 1'b1;
            state_n     = ST_HOLD;
          end else begin
            op_n        = op;
            acc_n       = new_beat_s;
            cnt_n       = CNT_ONE;
            out_valid_n = 1'b0;
            state_n     = ST_ACC;
          end
        end else if (take_s) begin
          out_valid_n = 1'b0;
          state_n     = ST_IDLE;
        end else begin
          state_n = state_r;
        end
      end
      ST_ACC: begin
        if (beat_s) begin
          acc_n = fold_s;
          cnt_n = cnt_inc_s;
          if (last) begin
            out_n       = finish_fn(op_r, fold_s);
            out_count_n = cnt_inc_s;
            out_valid_n = 1'b1;
            state_n     = ST_HOLD;
          end else begin
            state_n = ST_ACC;
          end
        end else begin
          state_n = ST_ACC;
        end
      end
      default: begin
        state_n     = ST_IDLE;
        out_valid_n = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any open frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      acc_r       <= {WIDTH{1'b0}};
      op_r        <= 2'b00;
      cnt_r       <= {CNT_W{1'b0}};
      out_r       <= {WIDTH{1'b0}};
      out_count_r <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      acc_r       <= acc_n;
      op_r        <= op_n;
      cnt_r       <= cnt_n;
      out_r       <= out_n;
      out_count_r <= out_count_n;
      out_valid_r <= out_valid_n;
    end
  end

  assign in_ready  = in_ready_s;
  assign out       = out_r;
  assign out_count = out_count_r;
  assign out_valid = out_valid_r;

endmodule
